// File: rtl/square_generic.sv
// square_generic: pipelined shift-and-add squarer, radicand = root*root (+ remainder).
// Ports: clk, rst_n, valid_in, root, [remainder if SQUARE_GENERIC_REMAINDER_EN], valid_out, radicand.
module square_generic #(
  parameter int WIDTH_INPUT  = 8,
  parameter int WIDTH_OUTPUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [WIDTH_INPUT-1:0]  root,
`ifdef SQUARE_GENERIC_REMAINDER_EN
  input  logic [WIDTH_INPUT:0]    remainder,
`endif
  output logic                    valid_out,
  output logic [WIDTH_OUTPUT-1:0] radicand
);

  localparam int W = WIDTH_INPUT;

  generate
    if (WIDTH_OUTPUT != 2 * WIDTH_INPUT) begin : g_bad_width
      $error("square_generic: WIDTH_OUTPUT must be 2*WIDTH_INPUT");
    end
  endgenerate

  logic                    r_valid [W];
  logic [W-1:0]            r_root  [W];
  logic [WIDTH_OUTPUT-1:0] r_acc   [W];

  logic [WIDTH_OUTPUT-1:0] w_seed;
  logic [WIDTH_OUTPUT-1:0] w_add   [W];

`ifdef SQUARE_GENERIC_REMAINDER_EN
  assign w_seed = WIDTH_OUTPUT'(remainder);
`else
  assign w_seed = '0;
`endif

  // Stage k adds root<<k when bit k of its own root copy is set.
  always_comb begin
    for (int k = 0; k < W; k++) begin
      w_add[k] = '0;
    end
    if (root[0]) begin
      w_add[0] = WIDTH_OUTPUT'(root);
    end
    for (int k = 1; k < W; k++) begin
      if (r_root[k-1][k]) begin
        w_add[k] = WIDTH_OUTPUT'(r_root[k-1]) << k;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < W; k++) begin
        r_valid[k] <= 1'b0;
        r_root[k]  <= '0;
        r_acc[k]   <= '0;
      end
    end else begin
      r_valid[0] <= valid_in;
      r_root[0]  <= root;
      r_acc[0]   <= w_seed + w_add[0];
      for (int k = 1; k < W; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_root[k]  <= r_root[k-1];
        r_acc[k]   <= r_acc[k-1] + w_add[k];
      end
    end
  end

  assign valid_out = r_valid[W-1];
  assign radicand  = r_acc[W-1];

endmodule
